// File: rtl/lsu_mem_issue_arbiter_if.sv
// lsu_mem_issue_arbiter_if: handshake bundle between AGEN/replay/cache/writeback and the LSU issue arbiter.
interface lsu_mem_issue_arbiter_if #(
  parameter int TAG_W  = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              recoverFlag_i;
  logic              agenValid_i;
  logic              agenIsLoad_i;
  logic [TAG_W-1:0]  agenTag_i;
  logic [ADDR_W-1:0] agenAddr_i;
  logic [DATA_W-1:0] agenData_i;
  logic              agenReady_o;
  logic              replayValid_i;
  logic [TAG_W-1:0]  replayTag_i;
  logic [ADDR_W-1:0] replayAddr_i;
  logic              replayReady_o;
  logic              ldReqValid_o;
  logic [TAG_W-1:0]  ldReqTag_o;
  logic [ADDR_W-1:0] ldReqAddr_o;
  logic              ldReqIsReplay_o;
  logic              ldReqReady_i;
  logic              stReqValid_o;
  logic [TAG_W-1:0]  stReqTag_o;
  logic [ADDR_W-1:0] stReqAddr_o;
  logic [DATA_W-1:0] stReqData_o;
  logic              stReqReady_i;
  logic              ldRespValid_i;
  logic [TAG_W-1:0]  ldRespTag_i;
  logic [DATA_W-1:0] ldRespData_i;
  logic              wbValid_o;
  logic [TAG_W-1:0]  wbTag_o;
  logic              wbIsStore_o;
  logic [DATA_W-1:0] wbData_o;
  modport slave (
    input  recoverFlag_i, agenValid_i, agenIsLoad_i, agenTag_i, agenAddr_i, agenData_i,
           replayValid_i, replayTag_i, replayAddr_i, ldReqReady_i, stReqReady_i,
           ldRespValid_i, ldRespTag_i, ldRespData_i,
    output agenReady_o, replayReady_o, ldReqValid_o, ldReqTag_o, ldReqAddr_o, ldReqIsReplay_o,
           stReqValid_o, stReqTag_o, stReqAddr_o, stReqData_o,
           wbValid_o, wbTag_o, wbIsStore_o, wbData_o
  );
  modport master (
    output recoverFlag_i, agenValid_i, agenIsLoad_i, agenTag_i, agenAddr_i, agenData_i,
           replayValid_i, replayTag_i, replayAddr_i, ldReqReady_i, stReqReady_i,
           ldRespValid_i, ldRespTag_i, ldRespData_i,
    input  agenReady_o, replayReady_o, ldReqValid_o, ldReqTag_o, ldReqAddr_o, ldReqIsReplay_o,
           stReqValid_o, stReqTag_o, stReqAddr_o, stReqData_o,
           wbValid_o, wbTag_o, wbIsStore_o, wbData_o
  );
endinterface

// File: rtl/lsu_mem_issue_arbiter.sv
// lsu_mem_issue_arbiter: load/store issue with starvation-bounded replay FIFO and store-completion writeback merge.
// Optional LSU_ARB_PERF_CTR_EN adds saturating replay-grant and AGEN-stall counters.
module lsu_mem_issue_arbiter #(
  parameter int TAG_W        = 7,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int REPLAY_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  lsu_mem_issue_arbiter_if.slave bus
`ifdef LSU_ARB_PERF_CTR_EN
  ,
  output logic [31:0] replayGrantCnt_o,
  output logic [31:0] agenStallCnt_o
`endif
);
  localparam int PW = $clog2(REPLAY_DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [TAG_W-1:0]  rtag_q [REPLAY_DEPTH];
  logic [ADDR_W-1:0] raddr_q [REPLAY_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ld_valid_q, ld_rep_q, st_valid_q, pend_q, wb_valid_q, wb_store_q;
  logic [TAG_W-1:0]  ld_tag_q, st_tag_q, pend_tag_q, wb_tag_q;
  logic [ADDR_W-1:0] ld_addr_q, st_addr_q;
  logic [DATA_W-1:0] st_data_q, wb_data_q;
  logic              rec, empty, full, ld_can, st_can, force_rep, agen_rdy;
  logic              ld_acc, st_acc, grant, push, drain, wb_valid_d;
  always_comb begin
    rec       = bus.recoverFlag_i;
    empty     = wr_q == rd_q;
    full      = (wr_q[PW-1] != rd_q[PW-1]) & (wr_q[AW-1:0] == rd_q[AW-1:0]);
    ld_can    = ~ld_valid_q | bus.ldReqReady_i;
    st_can    = ~st_valid_q | bus.stReqReady_i;
    force_rep = (starve_q == SW'(STARVE_LIMIT)) & ~empty;
    agen_rdy  = ~rec & (bus.agenIsLoad_i ? ld_can & ~force_rep : st_can & ~pend_q);
    ld_acc    = bus.agenValid_i & bus.agenIsLoad_i & agen_rdy;
    st_acc    = bus.agenValid_i & ~bus.agenIsLoad_i & agen_rdy;
    // A forced replay already dropped agen_rdy, so ld_acc is low and the replay wins.
    grant     = ~rec & ld_can & ~empty & ~ld_acc;
    push      = bus.replayValid_i & ~full & ~rec;
    drain     = pend_q & ~bus.ldRespValid_i & ~rec;
    wb_valid_d = bus.ldRespValid_i | drain;
    starve_d  = (rec | empty | grant) ? '0 :
                (ld_can & (starve_q != SW'(STARVE_LIMIT))) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rtag_q[wr_q[AW-1:0]]  <= bus.replayTag_i;
      raddr_q[wr_q[AW-1:0]] <= bus.replayAddr_i;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0; rd_q <= '0; starve_q <= '0;
      ld_valid_q <= 1'b0; ld_rep_q <= 1'b0; ld_tag_q <= '0; ld_addr_q <= '0;
      st_valid_q <= 1'b0; st_tag_q <= '0; st_addr_q <= '0; st_data_q <= '0;
      pend_q <= 1'b0; pend_tag_q <= '0;
      wb_valid_q <= 1'b0; wb_store_q <= 1'b0; wb_tag_q <= '0; wb_data_q <= '0;
    end else begin
      wr_q     <= rec ? '0 : wr_q + PW'(push);
      rd_q     <= rec ? '0 : rd_q + PW'(grant);
      starve_q <= starve_d;
      if (rec) ld_valid_q <= 1'b0;
      else if (ld_can) begin
        ld_valid_q <= ld_acc | grant;
        if (ld_acc | grant) begin
          ld_rep_q  <= grant;
          ld_tag_q  <= grant ? rtag_q[rd_q[AW-1:0]] : bus.agenTag_i;
          ld_addr_q <= grant ? raddr_q[rd_q[AW-1:0]] : bus.agenAddr_i;
        end
      end
      if (rec) st_valid_q <= 1'b0;
      else if (st_can) begin
        st_valid_q <= st_acc;
        if (st_acc) begin
          st_tag_q  <= bus.agenTag_i;
          st_addr_q <= bus.agenAddr_i;
          st_data_q <= bus.agenData_i;
        end
      end
      if (rec | drain) pend_q <= 1'b0;
      else if (st_acc) begin
        pend_q     <= 1'b1;
        pend_tag_q <= bus.agenTag_i;
      end
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_store_q <= ~bus.ldRespValid_i;
        wb_tag_q   <= bus.ldRespValid_i ? bus.ldRespTag_i : pend_tag_q;
        wb_data_q  <= bus.ldRespValid_i ? bus.ldRespData_i : '0;
      end
    end
  end
`ifdef LSU_ARB_PERF_CTR_EN
  logic [31:0] rg_cnt_q, as_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rg_cnt_q <= '0;
      as_cnt_q <= '0;
    end else begin
      if (grant & ~&rg_cnt_q) rg_cnt_q <= rg_cnt_q + 1'b1;
      if (bus.agenValid_i & ~agen_rdy & ~&as_cnt_q) as_cnt_q <= as_cnt_q + 1'b1;
    end
  end
  assign replayGrantCnt_o = rg_cnt_q;
  assign agenStallCnt_o   = as_cnt_q;
`endif
  assign bus.agenReady_o     = agen_rdy;
  assign bus.replayReady_o   = ~full;
  assign bus.ldReqValid_o    = ld_valid_q;
  assign bus.ldReqTag_o      = ld_tag_q;
  assign bus.ldReqAddr_o     = ld_addr_q;
  assign bus.ldReqIsReplay_o = ld_rep_q;
  assign bus.stReqValid_o    = st_valid_q;
  assign bus.stReqTag_o      = st_tag_q;
  assign bus.stReqAddr_o     = st_addr_q;
  assign bus.stReqData_o     = st_data_q;
  assign bus.wbValid_o       = wb_valid_q;
  assign bus.wbTag_o         = wb_tag_q;
  assign bus.wbIsStore_o     = wb_store_q;
  assign bus.wbData_o        = wb_data_q;
endmodule
